ppfifo_wr_arbiter: RTL and testbench
====================================

Name: ppfifo_wr_arbiter

Overview:
- Shares one ping-pong FIFO write port between two write-side requesters, e.g. two axi-stream-to-ppfifo adapters feeding one TFT pixel FIFO.
- Presents each requester a virtual ppfifo write interface (rdy/act/size/stb/data).
- Grants a whole downstream buffer to one requester at a time, with round-robin priority.
- Sits between the stream adapters and the physical ppfifo write controller.

Parameters:
- DATA_WIDTH, 32, payload width; every data bus is DATA_WIDTH+1 bits, with the MSB carrying "last".
- WDOG_CYCLES, 1024, grant-to-act timeout in clk cycles; used only with the watchdog feature.

Ports:
- clk  in  1  single clock; everything below is synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  2  per-requester request for a buffer; level, held until granted.
- o_gnt  out  2  one-hot grant; high from GRANT through RELEASE.
- o_r0_rdy  out  2  virtual ready to requester 0.
- i_r0_act  in  2  requester 0 activate.
- o_r0_size  out  24  size of the buffer presented to requester 0.
- i_r0_stb  in  1  requester 0 write strobe.
- i_r0_data  in  DATA_WIDTH+1  requester 0 write data.
- o_r1_rdy, i_r1_act, o_r1_size, i_r1_stb, i_r1_data: same as the r0 set, for requester 1.
- i_ppfifo_rdy  in  2  physical FIFO ready.
- o_ppfifo_act  out  2  physical FIFO activate.
- i_ppfifo_size  in  24  physical buffer size.
- o_ppfifo_stb  out  1  physical write strobe.
- o_ppfifo_data  out  DATA_WIDTH+1  physical write data.
- o_overflow  out  1  sticky flag: a strobe was dropped because the buffer was full.

Behaviour:
- Reset: all outputs 0, state IDLE, priority pointer = requester 0, internal count 0. Reset mid-transfer abandons the buffer; act drops asynchronously.
- IDLE:
  - Transition to GRANT when i_ppfifo_rdy!=0 and i_req!=0.
  - Winner: the pointed requester if it is requesting, otherwise the other one.
  - Same cycle: o_ppfifo_act gets rdy[0] ? 2'b01 : 2'b10; o_gnt is set; i_ppfifo_size is latched; count is cleared.
- GRANT:
  - Granted requester's o_rN_rdy equals o_ppfifo_act; o_rN_size equals the latched size.
  - The non-granted requester sees rdy=0 and size=0.
  - Go to XFER when the granted i_rN_act!=0.
- XFER:
  - Each granted strobe is registered: o_ppfifo_stb and o_ppfifo_data follow one cycle later.
  - Count increments per accepted strobe.
  - A strobe arriving when count==latched size is dropped and sets o_overflow.
  - Strobes from the non-granted requester are always ignored; they do not set overflow.
  - o_rN_rdy drops to 0 once act is seen.
  - When the granted act returns to 0, go to RELEASE.
- RELEASE (exactly 1 cycle):
  - The final registered strobe has already been issued.
  - o_ppfifo_act<=0, o_gnt<=0, priority pointer moves to the other requester, return to IDLE.
  - IDLE does not re-evaluate until the next cycle, so there is at least one cycle of act=0 between buffers.
- Zero-strobe release (act raised, then dropped with no strobes) is legal: the empty buffer is released.
- Simultaneous requests: the pointer decides. A lone requester may win back-to-back.
- A requester dropping i_req while in GRANT does not revoke the grant (watchdog excepted).
- Latency: 1 cycle from strobe to o_ppfifo_stb; 2 cycles from requester act-drop to o_ppfifo_act=0.

Optional Feature:
- Macro PPFIFO_ARB_WATCHDOG_EN.
- Defined:
  - A counter runs in GRANT.
  - If act is not seen within WDOG_CYCLES, the grant is revoked: go to RELEASE (empty buffer released) and the pointer advances.
  - Adds output o_wdog_fired (1 bit), a sticky flag cleared only by reset.
- Undefined: GRANT waits indefinitely; the port and counter are absent.

Decomposition:
- Package ppfifo_arb_pkg holds:
  - state localparams IDLE=0, GRANT=1, XFER=2, RELEASE=3;
  - PPFIFO_SIZE_W=24.
- One sub-module, rr_pick2: a combinational 2-way round-robin selector (inputs: req, pointer; outputs: one-hot winner, valid).

Test Plan:
- Single requester: r0 requests, rdy=01, size=4, 4 strobes with data 0x1..0x4, last on the 4th. Expect o_ppfifo_act=01, data 0x1..0x4 each one cycle delayed, bit32=1 on 0x4, act=0 two cycles after r0 act drops.
- Contention: both request continuously, rdy alternates 01/10. Expect grants r0,r1,r0,r1 on buffers 0,1,0,1, with no strobe from the ungranted requester reaching the output.
- Overflow: size=2, r1 strobes 3 times. Expect 2 output strobes and o_overflow=1 sticky.
- Zero-length: r0 raises act, then drops it with no strobes. Expect act released, o_ppfifo_stb never high, pointer moves to r1.
- Async reset: assert rst_n=0 mid-XFER after 2 of 4 strobes. Expect all outputs 0 immediately; after release, the next grant goes to r0.
- Watchdog (macro defined, WDOG_CYCLES=8): r0 granted, never activates. Expect release at cycle 8, o_wdog_fired=1, r1 granted next.

Source files
------------

// File: rtl/ppfifo_arb_pkg.sv
// Shared definitions for the ping-pong FIFO write arbiter.
// Holds the state codes, the buffer-size width and a small helper.
// Imported by ppfifo_wr_arbiter and rr_pick2.
package ppfifo_arb_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] XFER    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam int PPFIFO_SIZE_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT   = GRANT,
        ST_XFER    = XFER,
        ST_RELEASE = RELEASE
    } arb_state_t;

    // Buffer 0 is taken whenever it is ready, otherwise buffer 1.
    function automatic logic [1:0] act_for_rdy(input logic [1:0] rdy);
        return rdy[0] ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin selector, the pointed requester wins ties.
// Latency: purely combinational.
// Backpressure: none; win is one-hot or zero, win_vld flags any request.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       win_vld
);

    // Prefer the pointed requester, fall back to the other one.
    always_comb begin
        win = 2'b00;
        if (ptr) begin
            if (req[1])      win = 2'b10;
            else if (req[0]) win = 2'b01;
        end else begin
            if (req[0])      win = 2'b01;
            else if (req[1]) win = 2'b10;
        end
    end

    assign win_vld = |req;

endmodule

// File: rtl/ppfifo_wr_arbiter.sv
// ppfifo_wr_arbiter: shares one ppfifo write port between two requesters, one whole buffer per grant, round-robin.
// Latency: requester strobe -> o_ppfifo_stb 1 cycle; requester act drop -> o_ppfifo_act low 2 cycles.
// Backpressure: requesters wait on o_rN_rdy; strobes past the buffer size are dropped and flag o_overflow.
// Optional PPFIFO_ARB_WATCHDOG_EN: revoke a grant not activated within WDOG_CYCLES, adds o_wdog_fired.
module ppfifo_wr_arbiter
    import ppfifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32
`ifdef PPFIFO_ARB_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               i_req,
    output logic [1:0]               o_gnt,
    output logic [1:0]               o_r0_rdy,
    input  logic [1:0]               i_r0_act,
    output logic [PPFIFO_SIZE_W-1:0] o_r0_size,
    input  logic                     i_r0_stb,
    input  logic [DATA_WIDTH:0]      i_r0_data,
    output logic [1:0]               o_r1_rdy,
    input  logic [1:0]               i_r1_act,
    output logic [PPFIFO_SIZE_W-1:0] o_r1_size,
    input  logic                     i_r1_stb,
    input  logic [DATA_WIDTH:0]      i_r1_data,
    input  logic [1:0]               i_ppfifo_rdy,
    output logic [1:0]               o_ppfifo_act,
    input  logic [PPFIFO_SIZE_W-1:0] i_ppfifo_size,
    output logic                     o_ppfifo_stb,
    output logic [DATA_WIDTH:0]      o_ppfifo_data,
    output logic                     o_overflow
`ifdef PPFIFO_ARB_WATCHDOG_EN
    ,
    output logic                     o_wdog_fired
`endif
);

    arb_state_t                 state_q, state_d;
    logic [1:0]                 gnt_q, gnt_d;
    logic [1:0]                 act_q, act_d;
    logic [PPFIFO_SIZE_W-1:0]   size_q, size_d;
    logic [PPFIFO_SIZE_W-1:0]   cnt_q, cnt_d;
    logic                       ptr_q, ptr_d;
    logic                       ovf_q, ovf_d;
    logic                       stb_q, stb_d;
    logic [DATA_WIDTH:0]        data_q, data_d;

    logic [1:0]                 pick_win;
    logic                       pick_vld;

    // Granted-side view of the two virtual interfaces.
    logic                       g_sel;
    logic [1:0]                 g_act;
    logic                       g_stb;
    logic [DATA_WIDTH:0]        g_data;

    assign g_sel  = gnt_q[1];
    assign g_act  = g_sel ? i_r1_act  : i_r0_act;
    assign g_stb  = g_sel ? i_r1_stb  : i_r0_stb;
    assign g_data = g_sel ? i_r1_data : i_r0_data;

`ifdef PPFIFO_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
    logic [WDOG_W-1:0]          wdog_cnt_q, wdog_cnt_d;
    logic                       wdog_fired_q, wdog_fired_d;
`endif

    rr_pick2 u_pick (
        .req     (i_req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_vld (pick_vld)
    );

    // Buffer lifecycle: pick a winner, wait for its act, forward strobes, hand the buffer back.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        act_d   = act_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        stb_d   = 1'b0;
        data_d  = data_q;
`ifdef PPFIFO_ARB_WATCHDOG_EN
        wdog_cnt_d   = wdog_cnt_q;
        wdog_fired_d = wdog_fired_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((i_ppfifo_rdy != 2'b00) && pick_vld) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_win;
                    act_d   = act_for_rdy(i_ppfifo_rdy);
                    size_d  = i_ppfifo_size;
                    cnt_d   = '0;
`ifdef PPFIFO_ARB_WATCHDOG_EN
                    wdog_cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (g_act != 2'b00) begin
                    state_d = ST_XFER;
`ifdef PPFIFO_ARB_WATCHDOG_EN
                end else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    // Requester never took the buffer: hand it back empty.
                    state_d      = ST_RELEASE;
                    wdog_fired_d = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
`endif
                end
            end
            ST_XFER: begin
                if (g_stb) begin
                    if (cnt_q == size_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        stb_d  = 1'b1;
                        data_d = g_data;
                        cnt_d  = cnt_q + 24'd1;
                    end
                end
                if (g_act == 2'b00) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                act_d   = 2'b00;
                gnt_d   = 2'b00;
                // Next tie goes to whoever did not just own the buffer.
                ptr_d   = gnt_q[0];
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any buffer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            act_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            ovf_q   <= 1'b0;
            stb_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            act_q   <= act_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            stb_q   <= stb_d;
            data_q  <= data_d;
        end
    end

`ifdef PPFIFO_ARB_WATCHDOG_EN
    // Grant timeout counter and its sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q   <= '0;
            wdog_fired_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_fired_q <= wdog_fired_d;
        end
    end

    assign o_wdog_fired = wdog_fired_q;
`endif

    assign o_gnt         = gnt_q;
    assign o_ppfifo_act  = act_q;
    assign o_ppfifo_stb  = stb_q;
    assign o_ppfifo_data = data_q;
    assign o_overflow    = ovf_q;

    // Only the owner sees ready (until it activates) and the buffer size.
    assign o_r0_rdy  = ((state_q == ST_GRANT) && gnt_q[0]) ? act_q : 2'b00;
    assign o_r1_rdy  = ((state_q == ST_GRANT) && gnt_q[1]) ? act_q : 2'b00;
    assign o_r0_size = gnt_q[0] ? size_q : '0;
    assign o_r1_size = gnt_q[1] ? size_q : '0;

endmodule

// File: tb/tb_ppfifo_wr_arbiter.sv
// Bench for ppfifo_wr_arbiter: directed buffers from two requesters against a buffer-level model.
// Inputs change 1ns after the rising edge, the model advances on the rising edge, outputs are checked on the falling edge.
// PPFIFO_ARB_WATCHDOG_EN adds the grant-timeout scenario (WDOG_CYCLES = 8).
module tb_ppfifo_wr_arbiter;

    localparam int DATA_WIDTH = 32;
    localparam int DW         = DATA_WIDTH + 1;
    localparam int WDOG       = 8;

    logic          clk;
    logic          rst_n;
    logic [1:0]    i_req;
    logic [1:0]    o_gnt;
    logic [1:0]    o_r0_rdy, o_r1_rdy;
    logic [1:0]    i_r0_act, i_r1_act;
    logic [23:0]   o_r0_size, o_r1_size;
    logic          i_r0_stb, i_r1_stb;
    logic [DW-1:0] i_r0_data, i_r1_data;
    logic [1:0]    i_ppfifo_rdy;
    logic [1:0]    o_ppfifo_act;
    logic [23:0]   i_ppfifo_size;
    logic          o_ppfifo_stb;
    logic [DW-1:0] o_ppfifo_data;
    logic          o_overflow;
`ifdef PPFIFO_ARB_WATCHDOG_EN
    logic          o_wdog_fired;
`endif

    ppfifo_wr_arbiter #(
        .DATA_WIDTH (DATA_WIDTH)
`ifdef PPFIFO_ARB_WATCHDOG_EN
        ,
        .WDOG_CYCLES(WDOG)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (i_req),
        .o_gnt         (o_gnt),
        .o_r0_rdy      (o_r0_rdy),
        .i_r0_act      (i_r0_act),
        .o_r0_size     (o_r0_size),
        .i_r0_stb      (i_r0_stb),
        .i_r0_data     (i_r0_data),
        .o_r1_rdy      (o_r1_rdy),
        .i_r1_act      (i_r1_act),
        .o_r1_size     (o_r1_size),
        .i_r1_stb      (i_r1_stb),
        .i_r1_data     (i_r1_data),
        .i_ppfifo_rdy  (i_ppfifo_rdy),
        .o_ppfifo_act  (o_ppfifo_act),
        .i_ppfifo_size (i_ppfifo_size),
        .o_ppfifo_stb  (o_ppfifo_stb),
        .o_ppfifo_data (o_ppfifo_data),
        .o_overflow    (o_overflow)
`ifdef PPFIFO_ARB_WATCHDOG_EN
        ,
        .o_wdog_fired  (o_wdog_fired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model of what the outside world should see for the current buffer.
    logic [1:0]    m_act, m_gnt, m_vrdy;
    logic [23:0]   m_size;
    logic          m_stb, m_ovf, m_wdog;
    logic [DW-1:0] m_data;
    int            m_ptr;

    logic [DW-1:0] mon_q[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] req_act(input int n);
        return (n == 0) ? i_r0_act : i_r1_act;
    endfunction

    function automatic logic req_stb(input int n);
        return (n == 0) ? i_r0_stb : i_r1_stb;
    endfunction

    function automatic logic [DW-1:0] req_data(input int n);
        return (n == 0) ? i_r0_data : i_r1_data;
    endfunction

    task automatic model_reset();
        m_act  = 2'b00;
        m_gnt  = 2'b00;
        m_vrdy = 2'b00;
        m_size = '0;
        m_stb  = 1'b0;
        m_ovf  = 1'b0;
        m_wdog = 1'b0;
        m_data = '0;
        m_ptr  = 0;
    endtask

    task automatic mstep(output bit ab);
        @(posedge clk);
        m_stb = 1'b0;
        ab    = !rst_n;
        if (ab) model_reset();
    endtask

    // One buffer at a time: choose owner, wait for its act, count strobes, give the buffer back.
    task automatic model_loop();
        bit ab;
        bit seen;
        int own;
        int cnt;
        int wd;
        model_reset();
        forever begin
            mstep(ab);
            if (!ab && (i_ppfifo_rdy != 2'b00) && (i_req != 2'b00)) begin
                own    = i_req[m_ptr] ? m_ptr : 1 - m_ptr;
                m_gnt  = (own == 0) ? 2'b01 : 2'b10;
                m_act  = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                m_vrdy = m_act;
                m_size = i_ppfifo_size;
                cnt    = 0;
                wd     = 0;
                seen   = 1'b0;
                while (!ab && !seen) begin
                    mstep(ab);
                    if (!ab) begin
                        if (req_act(own) != 2'b00) begin
                            seen = 1'b1;
                        end else begin
`ifdef PPFIFO_ARB_WATCHDOG_EN
                            wd++;
                            if (wd == WDOG) begin
                                m_wdog = 1'b1;
                                break;
                            end
`endif
                        end
                    end
                end
                m_vrdy = 2'b00;
                while (!ab && seen) begin
                    mstep(ab);
                    if (!ab) begin
                        if (req_stb(own)) begin
                            if (cnt == int'(m_size)) begin
                                m_ovf = 1'b1;
                            end else begin
                                m_stb  = 1'b1;
                                m_data = req_data(own);
                                cnt++;
                            end
                        end
                        if (req_act(own) == 2'b00) break;
                    end
                end
                if (!ab) begin
                    mstep(ab);
                    if (!ab) begin
                        m_act = 2'b00;
                        m_gnt = 2'b00;
                        m_ptr = 1 - own;
                    end
                end
            end
        end
    endtask

    // Every falling edge: all outputs against the model; log output strobes.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("act",     o_ppfifo_act, rst_n ? m_act : 2'b00);
            chk("gnt",     o_gnt,        rst_n ? m_gnt : 2'b00);
            chk("stb",     o_ppfifo_stb, rst_n ? m_stb : 1'b0);
            chk("ovf",     o_overflow,   rst_n ? m_ovf : 1'b0);
            chk("r0_rdy",  o_r0_rdy,  (rst_n && m_gnt[0]) ? m_vrdy : 2'b00);
            chk("r1_rdy",  o_r1_rdy,  (rst_n && m_gnt[1]) ? m_vrdy : 2'b00);
            chk("r0_size", o_r0_size, (rst_n && m_gnt[0]) ? m_size : 24'd0);
            chk("r1_size", o_r1_size, (rst_n && m_gnt[1]) ? m_size : 24'd0);
`ifdef PPFIFO_ARB_WATCHDOG_EN
            chk("wdog",    o_wdog_fired, rst_n ? m_wdog : 1'b0);
`endif
            if (rst_n && m_stb) chk("data", o_ppfifo_data, m_data);
            if (rst_n && o_ppfifo_stb) mon_q.push_back(o_ppfifo_data);
        end
    endtask

    task automatic set_act(input int n, input logic [1:0] v);
        if (n == 0) i_r0_act = v;
        else        i_r1_act = v;
    endtask

    task automatic set_stb(input int n, input logic s, input logic [DW-1:0] d);
        if (n == 0) begin i_r0_stb = s; i_r0_data = d; end
        else        begin i_r1_stb = s; i_r1_data = d; end
    endtask

    task automatic wait_gnt(input logic [1:0] g);
        for (int i = 0; i < 40 && o_gnt != g; i++) tick();
        chk("grant_wait", o_gnt, g);
    endtask

    task automatic wait_rel();
        for (int i = 0; i < 40 && o_gnt != 2'b00; i++) tick();
        chk("release_wait", o_gnt, 2'b00);
    endtask

    task automatic chk_mon(input string nm, input logic [DW-1:0] e[$]);
        chk({nm, "_count"}, mon_q.size(), e.size());
        for (int i = 0; i < e.size() && i < mon_q.size(); i++) chk({nm, "_data"}, mon_q[i], e[i]);
        mon_q.delete();
    endtask

    // Serve one buffer for requester n: activate, nstb strobes (last flagged), release.
    task automatic run_buf(input int n, input int nstb, input logic [31:0] base,
                           input bit noise, input bit keep_req);
        logic [1:0]    ea;
        logic [DW-1:0] d;
        ea = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
        wait_gnt((n == 0) ? 2'b01 : 2'b10);
        chk("grant_act", o_ppfifo_act, ea);
        if (!keep_req) i_req[n] = 1'b0;
        set_act(n, ea);
        tick();
        for (int j = 0; j < nstb; j++) begin
            d = {1'b0, base + 32'(j)};
            d[DW-1] = (j == nstb - 1);
            set_stb(n, 1'b1, d);
            if (noise) set_stb(1 - n, 1'b1, {1'b0, 32'hDEAD_BEEF});
            tick();
        end
        set_stb(0, 1'b0, '0);
        set_stb(1, 1'b0, '0);
        tick();
        set_act(n, 2'b00);
        tick();
        chk("act_hold", o_ppfifo_act, ea);
        tick();
        chk("act_drop", o_ppfifo_act, 2'b00);
        wait_rel();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        i_req = 2'b00;
        i_r0_act = 2'b00; i_r1_act = 2'b00;
        i_r0_stb = 1'b0;  i_r1_stb = 1'b0;
        i_r0_data = '0;   i_r1_data = '0;
        i_ppfifo_rdy = 2'b00;
        i_ppfifo_size = 24'd0;

        fork
            model_loop();
            compare_loop();
            begin
                #200000;
                $display("FAIL global_timeout: simulation did not complete");
                $fatal(1, "timeout");
            end
        join_none

        // Reset state.
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("reset_gnt", o_gnt, 2'b00);
        chk("reset_act", o_ppfifo_act, 2'b00);
        chk("reset_ovf", o_overflow, 1'b0);

        // Single requester, 4-entry buffer, data 1..4 with last on 4.
        i_ppfifo_rdy  = 2'b01;
        i_ppfifo_size = 24'd4;
        i_req         = 2'b01;
        run_buf(0, 4, 32'h1, 1'b0, 1'b0);
        exp_q = '{33'h0_0000_0001, 33'h0_0000_0002, 33'h0_0000_0003, 33'h1_0000_0004};
        chk_mon("single", exp_q);

        // Reset in the middle of a transfer; pointer returns to requester 0.
        i_req = 2'b01;
        wait_gnt(2'b01);
        i_req = 2'b00;
        i_r0_act = 2'b01;
        tick();
        set_stb(0, 1'b1, {1'b0, 32'h21}); tick();
        set_stb(0, 1'b1, {1'b0, 32'h22}); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_act", o_ppfifo_act, 2'b00);
        chk("arst_gnt", o_gnt, 2'b00);
        chk("arst_stb", o_ppfifo_stb, 1'b0);
        set_stb(0, 1'b0, '0);
        i_r0_act = 2'b00;
        tick(); tick();
        rst_n = 1'b1;
        mon_q.delete();
        i_req = 2'b11;
        run_buf(0, 0, 32'h0, 1'b0, 1'b0);
        run_buf(1, 0, 32'h0, 1'b0, 1'b0);

        // Overflow: 2-entry buffer, three strobes from requester 1.
        i_ppfifo_rdy  = 2'b10;
        i_ppfifo_size = 24'd2;
        i_req         = 2'b10;
        run_buf(1, 3, 32'h10, 1'b0, 1'b0);
        exp_q = '{33'h0_0000_0010, 33'h0_0000_0011};
        chk_mon("overflow", exp_q);
        chk("overflow_flag", o_overflow, 1'b1);

        // Contention: both requesting, buffers alternate 0/1, ungranted side strobes junk.
        i_ppfifo_size = 24'd4;
        i_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            i_ppfifo_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            run_buf(k % 2, 2, 32'(256 * (k + 1)), 1'b1, 1'b1);
        end
        i_req = 2'b00;
        exp_q = '{33'h0_0000_0100, 33'h1_0000_0101, 33'h0_0000_0200, 33'h1_0000_0201,
                  33'h0_0000_0300, 33'h1_0000_0301, 33'h0_0000_0400, 33'h1_0000_0401};
        chk_mon("contention", exp_q);
        chk("overflow_sticky", o_overflow, 1'b1);

        // Zero-length buffer from requester 0, then a tie must go to requester 1.
        i_ppfifo_rdy = 2'b01;
        i_req = 2'b01;
        run_buf(0, 0, 32'h0, 1'b0, 1'b0);
        i_req = 2'b11;
        run_buf(1, 1, 32'h500, 1'b0, 1'b0);
        run_buf(0, 0, 32'h0, 1'b0, 1'b0);
        exp_q = '{33'h1_0000_0500};
        chk_mon("zero_len", exp_q);

`ifdef PPFIFO_ARB_WATCHDOG_EN
        // Requester 0 granted but never activates; requester 1 waits behind it.
        i_req = 2'b01;
        wait_gnt(2'b01);
        i_req = 2'b10;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 7) chk("wdog_early", o_wdog_fired, 1'b0);
            if (i == 8) chk("wdog_fire", o_wdog_fired, 1'b1);
            if (i == 8) chk("wdog_rel_gnt", o_gnt, 2'b01);
            if (i == 9) chk("wdog_idle_gnt", o_gnt, 2'b00);
        end
        run_buf(1, 0, 32'h0, 1'b0, 1'b0);
        chk("wdog_sticky", o_wdog_fired, 1'b1);
`endif

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
